// File: rtl/lru_ctrl.sv
// LRU table controller: initialises every set, then serves TOUCH and ALLOC
// requests as a read-modify-write of one 4-way true-LRU age byte.
module lru_ctrl #(
  parameter logic [7:0] INIT_STATE = 8'hE4,
  parameter int         NSETS_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [NSETS_LOG2-1:0] req_set,
  input  logic [1:0]            req_way,
  output logic                  resp_valid,
  output logic [1:0]            resp_way,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [NSETS_LOG2-1:0] ram_addr,
  output logic [7:0]            ram_din,
  input  logic [7:0]            ram_dout
);

  localparam logic [1:0] StInit = 2'd0;
  localparam logic [1:0] StIdle = 2'd1;
  localparam logic [1:0] StRd   = 2'd2;
  localparam logic [1:0] StWr   = 2'd3;

  localparam logic [NSETS_LOG2-1:0] CntOne = {{(NSETS_LOG2-1){1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic [NSETS_LOG2-1:0] cnt_q, cnt_d;
  logic [NSETS_LOG2-1:0] set_q, set_d;
  logic                  op_q, op_d;
  logic [1:0]            way_q, way_d;
  logic [1:0]            respWay_q, respWay_d;

  logic [1:0] maxAge;
  logic [1:0] victim;
  logic [1:0] target;
  logic [1:0] targetAge;
  logic [7:0] newByte;

  // Victim is the lowest-index way holding the largest age; a strict compare
  // keeps the first way found when several ways tie.
  always_comb begin
    maxAge = 2'd0;
    victim = 2'd0;
    for (int w = 0; w < 4; w++) begin
      if (ram_dout[2*w +: 2] > maxAge) begin
        maxAge = ram_dout[2*w +: 2];
        victim = 2'(w);
      end
    end
  end

  // Ways younger than the target age by one; the target becomes MRU.
  always_comb begin
    target    = op_q ? victim : way_q;
    targetAge = ram_dout[{target, 1'b0} +: 2];
    newByte   = 8'h00;
    for (int w = 0; w < 4; w++) begin
      if (2'(w) == target) begin
        newByte[2*w +: 2] = 2'd0;
      end else if (ram_dout[2*w +: 2] < targetAge) begin
        newByte[2*w +: 2] = ram_dout[2*w +: 2] + 2'd1;
      end else begin
        newByte[2*w +: 2] = ram_dout[2*w +: 2];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    set_d     = set_q;
    op_d      = op_q;
    way_d     = way_q;
    respWay_d = respWay_q;
    case (state_q)
      StInit: begin
        cnt_d = cnt_q + CntOne;
        if (cnt_q == '1) state_d = StIdle;
      end
      StIdle: begin
        if (req_valid) begin
          set_d   = req_set;
          op_d    = req_op;
          way_d   = req_way;
          state_d = StRd;
        end
      end
      StRd: state_d = StWr;
      StWr: begin
        respWay_d = target;
        state_d   = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StInit;
      cnt_q     <= '0;
      set_q     <= '0;
      op_q      <= 1'b0;
      way_q     <= 2'd0;
      respWay_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      set_q     <= set_d;
      op_q      <= op_d;
      way_q     <= way_d;
      respWay_q <= respWay_d;
    end
  end

  // While reset is held the RAM port stays quiet so no stray init write lands.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_way   = rst ? 2'd0 : respWay_q;
    ram_ena    = 1'b0;
    ram_wea    = 1'b0;
    ram_addr   = '0;
    ram_din    = 8'h00;
    if (!rst) begin
      case (state_q)
        StInit: begin
          ram_ena  = 1'b1;
          ram_wea  = 1'b1;
          ram_addr = cnt_q;
          ram_din  = INIT_STATE;
        end
        StIdle: req_ready = 1'b1;
        StRd: begin
          ram_ena  = 1'b1;
          ram_addr = set_q;
        end
        StWr: begin
          ram_ena    = 1'b1;
          ram_wea    = 1'b1;
          ram_addr   = set_q;
          ram_din    = newByte;
          resp_valid = 1'b1;
          resp_way   = target;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lru_ctrl.sv
// Bench for lru_ctrl: models the LRU RAM, runs directed vectors, a random
// request stream against an age-list reference model, and reset corner cases.
module tb_lru_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_op;
  logic [5:0] req_set;
  logic [1:0] req_way;
  logic       resp_valid;
  logic [1:0] resp_way;
  logic       ram_ena;
  logic       ram_wea;
  logic [5:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  logic [7:0] mem [64];
  logic [7:0] shadow [64];
  logic       preEn;
  logic [5:0] preAddr;
  logic [7:0] preData;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    logic       preEn;
    logic [7:0] preData;
    logic       op;
    logic [5:0] set;
    logic [1:0] way;
    logic [1:0] expWay;
    logic [7:0] expDin;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  lru_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_set   (req_set),
    .req_way   (req_way),
    .resp_valid(resp_valid),
    .resp_way  (resp_way),
    .ram_ena   (ram_ena),
    .ram_wea   (ram_wea),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  // Read-first RAM with a side port the bench uses to plant arbitrary bytes.
  always @(posedge clk) begin
    if (preEn) begin
      mem[preAddr] <= preData;
    end else if (ram_ena) begin
      ram_dout <= mem[ram_addr];
      if (ram_wea) mem[ram_addr] <= ram_din;
    end
  end

  // Reference model: ages as plain integers, victim found by searching for the max.
  function automatic void refLru(input logic [7:0] old, input logic op, input logic [1:0] way,
                                 output logic [1:0] t, output logic [7:0] nb);
    int age [4];
    int best;
    int a;
    for (int i = 0; i < 4; i++) age[i] = int'(old[2*i +: 2]);
    if (op) begin
      best = 0;
      for (int i = 1; i < 4; i++) if (age[i] > age[best]) best = i;
      t = 2'(best);
    end else begin
      t = way;
    end
    nb = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (i == int'(t)) a = 0;
      else if (age[i] < age[int'(t)]) a = age[i] + 1;
      else a = age[i];
      nb[2*i +: 2] = 2'(a);
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [5:0] set, input logic [7:0] data);
    preEn   = 1'b1;
    preAddr = set;
    preData = data;
    @(posedge clk); #1;
    preEn = 1'b0;
    shadow[set] = data;
  endtask

  // Entered and left one time unit after a rising edge.
  task automatic runInit(input string tag);
    @(negedge clk);
    checkOutput({tag, " reset outputs"},
                32'({req_ready, resp_valid, resp_way, ram_wea, ram_addr, ram_din}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s init write %0d", tag, k),
                  32'({req_ready, resp_valid, ram_ena, ram_wea, ram_addr, ram_din}),
                  32'({1'b0, 1'b0, 1'b1, 1'b1, 6'(k), 8'hE4}));
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput({tag, " ready after init"}, 32'({req_ready, ram_ena}), 32'b10);
    @(posedge clk); #1;
    for (int s = 0; s < 64; s++) shadow[s] = 8'hE4;
  endtask

  task automatic applyStimulus(input logic op, input logic [5:0] set, input logic [1:0] way,
                               input logic [1:0] expWay, input logic [7:0] expDin, input string tag);
    int waited = 0;
    while (!req_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 200) begin
      checkOutput({tag, " ready timeout"}, 32'(req_ready), 32'h1);
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_set   = set;
    req_way   = way;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = ~op;
    req_way   = ~way;
    @(negedge clk);
    checkOutput({tag, " read cycle"},
                32'({req_ready, resp_valid, ram_ena, ram_wea, ram_addr}),
                32'({1'b0, 1'b0, 1'b1, 1'b0, set}));
    @(negedge clk);
    checkOutput({tag, " write cycle"},
                32'({resp_valid, ram_ena, ram_wea, ram_addr}), 32'({3'b111, set}));
    checkOutput({tag, " resp_way"}, 32'(resp_way), 32'(expWay));
    checkOutput({tag, " ram_din"}, 32'(ram_din), 32'(expDin));
    @(negedge clk);
    checkOutput({tag, " back to idle"},
                32'({req_ready, resp_valid, ram_ena, resp_way}), 32'({3'b100, expWay}));
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] mWay;
    logic [7:0] mByte;
    logic       rOp;
    logic [5:0] rSet;
    logic [1:0] rWay;
    int         waited;

    vecs[0]  = '{1'b0, 8'h00, 1'b1, 6'd5,  2'd0, 2'd3, 8'h39};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 6'd5,  2'd1, 2'd1, 8'h72};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 6'd5,  2'd0, 2'd2, 8'h87};
    vecs[3]  = '{1'b1, 8'hE4, 1'b0, 6'd9,  2'd0, 2'd0, 8'hE4};
    vecs[4]  = '{1'b1, 8'h00, 1'b1, 6'd10, 2'd3, 2'd0, 8'h00};
    vecs[5]  = '{1'b1, 8'hFF, 1'b0, 6'd11, 2'd2, 2'd2, 8'hCF};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 6'd63, 2'd1, 2'd3, 8'h39};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 6'd0,  2'd3, 2'd3, 8'h39};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 6'd1,  2'd2, 2'd2, 8'hC9};
    vecs[9]  = '{1'b1, 8'h1B, 1'b1, 6'd12, 2'd2, 2'd0, 8'h6C};
    vecs[10] = '{1'b1, 8'h5A, 1'b1, 6'd13, 2'd1, 2'd0, 8'hA8};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_set   = 6'd0;
    req_way   = 2'd0;
    preEn     = 1'b0;
    preAddr   = 6'd0;
    preData   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    runInit("power-on");

    foreach (vecs[i]) begin
      if (vecs[i].preEn) preload(vecs[i].set, vecs[i].preData);
      applyStimulus(vecs[i].op, vecs[i].set, vecs[i].way, vecs[i].expWay, vecs[i].expDin,
                    $sformatf("vec%0d", i));
      shadow[vecs[i].set] = vecs[i].expDin;
    end

    // Two requests with req_valid held high: the second waits for IDLE.
    req_valid = 1'b1;
    req_op    = 1'b1;
    req_set   = 6'd20;
    req_way   = 2'd0;
    @(posedge clk); #1;
    req_op  = 1'b0;
    req_set = 6'd21;
    req_way = 2'd1;
    @(negedge clk);
    checkOutput("b2b first read",
                32'({req_ready, ram_ena, ram_wea, ram_addr}), 32'({3'b010, 6'd20}));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("b2b first write",
                32'({req_ready, resp_valid, resp_way, ram_wea, ram_addr, ram_din}),
                32'({1'b0, 1'b1, 2'd3, 1'b1, 6'd20, 8'h39}));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("b2b idle gap", 32'({req_ready, resp_valid, ram_ena}), 32'b100);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b second read",
                32'({req_ready, ram_ena, ram_wea, ram_addr}), 32'({3'b010, 6'd21}));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("b2b second write",
                32'({resp_valid, resp_way, ram_wea, ram_addr, ram_din}),
                32'({1'b1, 2'd1, 1'b1, 6'd21, 8'hE1}));
    @(posedge clk); #1;
    shadow[20] = 8'h39;
    shadow[21] = 8'hE1;

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(4) == 0) preload(6'($urandom_range(63)), 8'($urandom));
      rOp  = 1'($urandom);
      rSet = 6'($urandom_range(63));
      rWay = 2'($urandom);
      refLru(shadow[rSet], rOp, rWay, mWay, mByte);
      applyStimulus(rOp, rSet, rWay, mWay, mByte, $sformatf("rand%0d", i));
      shadow[rSet] = mByte;
    end

    // Reset while a request sits in its read cycle.
    waited = 0;
    while (!req_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("abort ready", 32'(req_ready), 32'h1);
    req_valid = 1'b1;
    req_op    = 1'b1;
    req_set   = 6'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort read cycle", 32'({ram_ena, ram_wea, ram_addr}), 32'({2'b10, 6'd7}));
    rst = 1'b1;
    @(posedge clk); #1;
    runInit("abort");
    applyStimulus(1'b1, 6'd7, 2'd0, 2'd3, 8'h39, "after abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
